kuznechik_apb_fifo_wrapper: RTL and testbench

Second-generation APB slave front-end for the Kuznechik cipher core, generalised in block width and in the number of queued blocks. Software streams plaintext words into an input FIFO. An internal sequencer feeds the core one block at a time using its req/busy/valid/ack protocol. Results collect in an output FIFO that software drains word by word, with status counters and a completion interrupt. The core is instantiated outside this block and connected through the cipher_* ports.

---
 rtl/kuznechik_apb_fifo_wrapper.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_kuznechik_apb_fifo_wrapper.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kuznechik_apb_fifo_wrapper.sv
// APB slave front-end for the Kuznechik cipher core.
// Software streams plaintext words into an input FIFO. A small sequencer
// hands one block at a time to the external core over req/busy/valid/ack.
// Results collect in an output FIFO that software drains word by word.
module kuznechik_apb_fifo_wrapper #(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int APB_DATA_WIDTH = 32,
    parameter int BLOCK_WIDTH    = 128,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic [APB_ADDR_WIDTH-1:0] apb_paddr_i,
    input  logic [APB_DATA_WIDTH-1:0] apb_pwdata_i,
    input  logic                      apb_pwrite_i,
    input  logic                      apb_psel_i,
    input  logic                      apb_penable_i,
    output logic [APB_DATA_WIDTH-1:0] apb_prdata_o,
    output logic                      apb_pready_o,
    output logic                      apb_pslverr_o,
    output logic                      irq_o,
    output logic                      cipher_rstn_o,
    output logic                      cipher_req_o,
    output logic                      cipher_ack_o,
    output logic [BLOCK_WIDTH-1:0]    cipher_data_o,
    input  logic                      cipher_busy_i,
    input  logic                      cipher_valid_i,
    input  logic [BLOCK_WIDTH-1:0]    cipher_data_i
);

    localparam int WORDS = BLOCK_WIDTH / APB_DATA_WIDTH;
    localparam int WPW   = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = AW + 1;

    localparam logic [CW-1:0]  DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [WPW-1:0] LAST_W  = WPW'(WORDS - 1);

    localparam logic [APB_ADDR_WIDTH-1:0] A_CTRL   = APB_ADDR_WIDTH'('h00);
    localparam logic [APB_ADDR_WIDTH-1:0] A_STATUS = APB_ADDR_WIDTH'('h04);
    localparam logic [APB_ADDR_WIDTH-1:0] A_DIN    = APB_ADDR_WIDTH'('h08);
    localparam logic [APB_ADDR_WIDTH-1:0] A_DOUT   = APB_ADDR_WIDTH'('h0C);
    localparam logic [APB_ADDR_WIDTH-1:0] A_IRQ    = APB_ADDR_WIDTH'('h10);
    localparam logic [APB_ADDR_WIDTH-1:0] A_WORDS  = APB_ADDR_WIDTH'('h14);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_ACK} state_t;

    state_t state;

    logic ctrl_en, ctrl_irq_en, done;

    logic [BLOCK_WIDTH-1:0] in_mem  [FIFO_DEPTH];
    logic [BLOCK_WIDTH-1:0] out_mem [FIFO_DEPTH];
    logic [AW-1:0]          in_wr, in_rd, out_wr, out_rd;
    logic [CW-1:0]          in_count, out_count;
    logic [WPW-1:0]         wptr, rptr;
    logic [BLOCK_WIDTH-1:0] din_buf, din_next;

    logic [APB_DATA_WIDTH-1:0] rd_val, dout_word;
    logic setup, access, commit, err;
    logic is_ctrl, is_status, is_din, is_dout, is_irq, is_words, mapped;
    logic wr_ctrl, wr_irq, wr_din, rd_dout, din_last;
    logic in_full, in_empty, out_full, out_empty;
    logic in_push, in_pop, out_push, out_pop, seq_start, done_set;

    assign setup  = apb_psel_i & ~apb_penable_i;
    assign access = apb_psel_i & apb_penable_i & apb_pready_o;
    // The error decision latched in the setup cycle also gates the commit.
    assign commit = access & ~apb_pslverr_o;

    assign is_ctrl   = (apb_paddr_i == A_CTRL);
    assign is_status = (apb_paddr_i == A_STATUS);
    assign is_din    = (apb_paddr_i == A_DIN);
    assign is_dout   = (apb_paddr_i == A_DOUT);
    assign is_irq    = (apb_paddr_i == A_IRQ);
    assign is_words  = (apb_paddr_i == A_WORDS);
    assign mapped    = is_ctrl | is_status | is_din | is_dout | is_irq | is_words;

    assign in_full   = (in_count == DEPTH_C);
    assign in_empty  = (in_count == '0);
    assign out_full  = (out_count == DEPTH_C);
    assign out_empty = (out_count == '0);

    assign err = ~mapped
               | (apb_pwrite_i & (is_status | is_dout | is_words))
               | (~apb_pwrite_i & is_din)
               | (apb_pwrite_i & is_din & in_full & (wptr == '0))
               | (~apb_pwrite_i & is_dout & out_empty);

    assign wr_ctrl  = commit & apb_pwrite_i & is_ctrl;
    assign wr_irq   = commit & apb_pwrite_i & is_irq;
    assign wr_din   = commit & apb_pwrite_i & is_din;
    assign rd_dout  = commit & ~apb_pwrite_i & is_dout;
    assign din_last = wr_din & (wptr == LAST_W);

    assign in_push   = ctrl_en & din_last;
    assign in_pop    = ctrl_en & (state == S_REQ);
    assign out_push  = ctrl_en & (state == S_ACK);
    assign out_pop   = ctrl_en & rd_dout & (rptr == LAST_W);
    assign done_set  = ctrl_en & (state == S_ACK);
    assign seq_start = ctrl_en & ~in_empty & ~out_full & ~cipher_busy_i;

    assign cipher_rstn_o = rstn_i & ctrl_en;

    // Merge the incoming DIN word into the partially assembled block.
    always_comb begin
        din_next = din_buf;
        for (int i = 0; i < WORDS; i++) begin
            if (wptr == WPW'(i)) begin
                din_next[i*APB_DATA_WIDTH +: APB_DATA_WIDTH] = apb_pwdata_i;
            end
        end
    end

    // Select word rptr of the output FIFO head.
    always_comb begin
        dout_word = '0;
        for (int i = 0; i < WORDS; i++) begin
            if (rptr == WPW'(i)) begin
                dout_word = out_mem[out_rd][i*APB_DATA_WIDTH +: APB_DATA_WIDTH];
            end
        end
    end

    // Register read mux.
    always_comb begin
        rd_val = '0;
        if (is_ctrl) begin
            rd_val[1:0] = {ctrl_irq_en, ctrl_en};
        end else if (is_status) begin
            rd_val[7:0]  = 8'(in_count);
            rd_val[15:8] = 8'(out_count);
            rd_val[16]   = in_full;
            rd_val[17]   = out_empty;
            rd_val[18]   = (state != S_IDLE);
        end else if (is_dout) begin
            rd_val = out_empty ? '0 : dout_word;
        end else if (is_irq) begin
            rd_val[0] = done;
        end else if (is_words) begin
            rd_val = APB_DATA_WIDTH'(WORDS);
        end
    end

    // APB response: registered in setup so it is ready in the first access cycle.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            apb_pready_o  <= 1'b0;
            apb_pslverr_o <= 1'b0;
            apb_prdata_o  <= '0;
        end else if (setup) begin
            apb_pready_o  <= 1'b1;
            apb_pslverr_o <= err;
            apb_prdata_o  <= (apb_pwrite_i | err) ? '0 : rd_val;
        end else begin
            apb_pready_o  <= 1'b0;
            apb_pslverr_o <= 1'b0;
            apb_prdata_o  <= '0;
        end
    end

    // Control, DONE flag (set beats clear) and registered interrupt.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ctrl_en     <= 1'b0;
            ctrl_irq_en <= 1'b0;
            done        <= 1'b0;
            irq_o       <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                ctrl_en     <= apb_pwdata_i[0];
                ctrl_irq_en <= apb_pwdata_i[1];
            end
            if (done_set) begin
                done <= 1'b1;
            end else if (wr_irq & apb_pwdata_i[0]) begin
                done <= 1'b0;
            end
            irq_o <= ctrl_irq_en & done;
        end
    end

    // DIN word assembly; the pointer is cleared by soft reset.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wptr    <= '0;
            din_buf <= '0;
        end else if (!ctrl_en) begin
            wptr <= '0;
        end else if (wr_din) begin
            din_buf <= din_next;
            wptr    <= din_last ? '0 : wptr + WPW'(1);
        end
    end

    // FIFO storage carries no reset; validity is tracked by the counters.
    always_ff @(posedge clk_i) begin
        if (in_push) begin
            in_mem[in_wr] <= din_next;
        end
        if (out_push) begin
            out_mem[out_wr] <= cipher_data_i;
        end
    end

    // Input FIFO pointers and occupancy.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            in_wr    <= '0;
            in_rd    <= '0;
            in_count <= '0;
        end else if (!ctrl_en) begin
            in_wr    <= '0;
            in_rd    <= '0;
            in_count <= '0;
        end else begin
            if (in_push) in_wr <= in_wr + AW'(1);
            if (in_pop)  in_rd <= in_rd + AW'(1);
            in_count <= in_count + CW'(in_push) - CW'(in_pop);
        end
    end

    // Output FIFO pointers, occupancy and DOUT word pointer.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            out_wr    <= '0;
            out_rd    <= '0;
            out_count <= '0;
            rptr      <= '0;
        end else if (!ctrl_en) begin
            out_wr    <= '0;
            out_rd    <= '0;
            out_count <= '0;
            rptr      <= '0;
        end else begin
            if (out_push) out_wr <= out_wr + AW'(1);
            if (out_pop)  out_rd <= out_rd + AW'(1);
            if (rd_dout)  rptr   <= (rptr == LAST_W) ? '0 : rptr + WPW'(1);
            out_count <= out_count + CW'(out_push) - CW'(out_pop);
        end
    end

    // Sequencer: one block per IDLE -> REQ -> WAIT -> ACK round trip.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state         <= S_IDLE;
            cipher_req_o  <= 1'b0;
            cipher_ack_o  <= 1'b0;
            cipher_data_o <= '0;
        end else if (!ctrl_en) begin
            state        <= S_IDLE;
            cipher_req_o <= 1'b0;
            cipher_ack_o <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (seq_start) begin
                        state         <= S_REQ;
                        cipher_req_o  <= 1'b1;
                        cipher_data_o <= in_mem[in_rd];
                    end
                end
                S_REQ: begin
                    cipher_req_o <= 1'b0;
                    state        <= S_WAIT;
                end
                S_WAIT: begin
                    if (cipher_valid_i) begin
                        state        <= S_ACK;
                        cipher_ack_o <= 1'b1;
                    end
                end
                S_ACK: begin
                    cipher_ack_o <= 1'b0;
                    state        <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_kuznechik_apb_fifo_wrapper.sv
// Scoreboard bench for kuznechik_apb_fifo_wrapper with a behavioural core
// that returns the bitwise inverse of each block after a fixed latency.
module tb_kuznechik_apb_fifo_wrapper;

    localparam int AW  = 12;
    localparam int DW  = 32;
    localparam int BW  = 128;
    localparam int LAT = 10;

    localparam logic [11:0] A_CTRL   = 12'h000;
    localparam logic [11:0] A_STATUS = 12'h004;
    localparam logic [11:0] A_DIN    = 12'h008;
    localparam logic [11:0] A_DOUT   = 12'h00C;
    localparam logic [11:0] A_IRQ    = 12'h010;
    localparam logic [11:0] A_WORDS  = 12'h014;

    logic          clk = 1'b0;
    logic          rstn;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic          pwrite, psel, penable;
    logic [DW-1:0] prdata;
    logic          pready, pslverr, irq;
    logic          c_rstn, c_req, c_ack;
    logic [BW-1:0] c_dout;
    logic          c_busy, c_valid;
    logic [BW-1:0] c_din;

    int checks   = 0;
    int failures = 0;
    int xfers    = 0;
    int pready_cycles = 0;
    bit stall       = 1'b0;
    bit force_valid = 1'b0;

    typedef struct {
        logic [31:0] data;
        bit          chk_data;
        bit          err;
    } apb_exp_t;

    apb_exp_t      apb_q[$];
    string         apb_nm[$];
    logic [BW-1:0] req_q[$];

    always #5 clk = ~clk;

    kuznechik_apb_fifo_wrapper #(
        .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .BLOCK_WIDTH(BW), .FIFO_DEPTH(4)
    ) dut (
        .clk_i(clk), .rstn_i(rstn),
        .apb_paddr_i(paddr), .apb_pwdata_i(pwdata), .apb_pwrite_i(pwrite),
        .apb_psel_i(psel), .apb_penable_i(penable),
        .apb_prdata_o(prdata), .apb_pready_o(pready), .apb_pslverr_o(pslverr),
        .irq_o(irq),
        .cipher_rstn_o(c_rstn), .cipher_req_o(c_req), .cipher_ack_o(c_ack),
        .cipher_data_o(c_dout), .cipher_busy_i(c_busy), .cipher_valid_i(c_valid),
        .cipher_data_i(c_din)
    );

    function automatic logic [31:0] wv(input int b, input int j);
        return 32'hC0DE0000 | 32'(b << 4) | 32'(j);
    endfunction

    function automatic logic [BW-1:0] blk(input int b);
        return {wv(b, 3), wv(b, 2), wv(b, 1), wv(b, 0)};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // APB monitor: every ready cycle must match the oldest expectation.
    initial begin : apb_mon
        apb_exp_t e;
        string    nm;
        forever begin
            @(negedge clk);
            if (pready === 1'b1) begin
                pready_cycles++;
                checks++;
                if (apb_q.size() == 0) begin
                    failures++;
                    $display("FAIL apb_unexpected: pready with no transfer pending");
                end else begin
                    e  = apb_q.pop_front();
                    nm = apb_nm.pop_front();
                    if (pslverr !== e.err || (e.chk_data && prdata !== e.data)) begin
                        failures++;
                        $display("FAIL %s: got err=%0b data=%h, expected err=%0b data=%h",
                                 nm, pslverr, prdata, e.err, e.data);
                    end
                end
            end
        end
    end

    // Request monitor: each req pulse must carry the next queued block.
    initial begin : req_mon
        logic [BW-1:0] e;
        forever begin
            @(negedge clk);
            if (c_req === 1'b1) begin
                checks++;
                if (req_q.size() == 0) begin
                    failures++;
                    $display("FAIL req_unexpected: req with data %h", c_dout);
                end else begin
                    e = req_q.pop_front();
                    if (c_dout !== e) begin
                        failures++;
                        $display("FAIL req_data: got %h, expected %h", c_dout, e);
                    end
                end
            end
        end
    end

    // Core model: inverts the block, LAT cycles after req, holds valid until ack.
    initial begin : core
        logic [BW-1:0] cap;
        int cnt;
        bit ack_seen;
        c_busy = 1'b0; c_valid = 1'b0; c_din = '0;
        cap = '0; cnt = 0; ack_seen = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (c_rstn !== 1'b1) begin
                c_busy = 1'b0; c_valid = 1'b0; ack_seen = 1'b0;
            end else if (ack_seen) begin
                c_busy = 1'b0; c_valid = 1'b0; ack_seen = 1'b0;
            end else if (c_req === 1'b1) begin
                cap = c_dout; c_busy = 1'b1; cnt = LAT;
            end else if (c_busy && !c_valid) begin
                if (force_valid) cnt = 0;
                else if (!stall && cnt > 0) cnt--;
                if (cnt == 0) begin
                    c_valid = 1'b1;
                    c_din   = ~cap;
                end
            end else if (c_valid && c_ack === 1'b1) begin
                ack_seen = 1'b1;
            end
        end
    end

    task automatic apb(input bit wr, input logic [11:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp, input bit chk_d, input bit eerr,
                       input string nm);
        apb_exp_t e;
        e.data = exp; e.chk_data = chk_d; e.err = eerr;
        apb_q.push_back(e);
        apb_nm.push_back(nm);
        xfers++;
        @(posedge clk); #1;
        paddr = addr; pwdata = wd; pwrite = wr; psel = 1'b1; penable = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic rd(input logic [11:0] a, input logic [31:0] exp, input string nm);
        apb(1'b0, a, 32'h0, exp, 1'b1, 1'b0, nm);
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d, input string nm);
        apb(1'b1, a, d, 32'h0, 1'b0, 1'b0, nm);
    endtask

    task automatic wait_irq(input logic lvl, input int maxc, input string nm);
        int n = 0;
        while (irq !== lvl && n < maxc) begin
            @(posedge clk); #1;
            n++;
        end
        chk(nm, 32'(irq), 32'(lvl));
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        rstn = 1'b0; paddr = '0; pwdata = '0; pwrite = 1'b0; psel = 1'b0; penable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cipher_rstn", 32'(c_rstn), 0);
        chk("rst_irq", 32'(irq), 0);
        chk("rst_pready", 32'(pready), 0);
        chk("rst_req_ack", 32'({c_req, c_ack}), 0);
        rstn = 1'b1;
        @(posedge clk); #1;
        chk("cipher_rstn_en0", 32'(c_rstn), 0);
        rd(A_STATUS, 32'h0002_0000, "status_reset");
        rd(A_CTRL, 32'h0, "ctrl_reset");
        rd(A_WORDS, 32'h4, "words");

        // single block round trip
        wr(A_CTRL, 32'h3, "ctrl_en");
        chk("cipher_rstn_en1", 32'(c_rstn), 1);
        req_q.push_back(128'h44444444_33333333_22222222_11111111);
        wr(A_DIN, 32'h11111111, "din0");
        wr(A_DIN, 32'h22222222, "din1");
        wr(A_DIN, 32'h33333333, "din2");
        wr(A_DIN, 32'h44444444, "din3");
        wait_irq(1'b1, 100, "irq_done");
        rd(A_IRQ, 32'h1, "irq_stat_done");
        rd(A_DOUT, 32'hEEEEEEEE, "dout0");
        rd(A_DOUT, 32'hDDDDDDDD, "dout1");
        rd(A_DOUT, 32'hCCCCCCCC, "dout2");
        rd(A_DOUT, 32'hBBBBBBBB, "dout3");
        apb(1'b0, A_DOUT, 32'h0, 32'h0, 1'b1, 1'b1, "dout_empty_err");
        wr(A_IRQ, 32'h1, "w1c_first");
        repeat (2) @(posedge clk);
        #1;
        chk("irq_cleared", 32'(irq), 0);

        // fill the input FIFO behind a stalled core
        stall = 1'b1;
        for (int b = 0; b < 5; b++) begin
            req_q.push_back(blk(b));
            for (int j = 0; j < 4; j++) wr(A_DIN, wv(b, j), "din_fill");
        end
        rd(A_STATUS, 32'h0007_0004, "status_in_full");
        apb(1'b1, A_DIN, wv(5, 0), 32'h0, 1'b0, 1'b1, "din_full_err");
        rd(A_STATUS, 32'h0007_0004, "status_after_full_err");
        stall = 1'b0;
        repeat (200) @(posedge clk);
        #1;
        rd(A_STATUS, 32'h0000_0401, "status_out_full");
        for (int b = 0; b < 4; b++)
            for (int j = 0; j < 4; j++) rd(A_DOUT, ~wv(b, j), "dout_drain");
        repeat (40) @(posedge clk);
        #1;
        for (int j = 0; j < 4; j++) rd(A_DOUT, ~wv(4, j), "dout_last_blk");

        // soft reset during WAIT with a partial DIN block pending
        stall = 1'b1;
        req_q.push_back(blk(6));
        for (int j = 0; j < 4; j++) wr(A_DIN, wv(6, j), "din_blk6");
        wr(A_DIN, wv(7, 0), "din_partial");
        wr(A_CTRL, 32'h2, "ctrl_dis");
        chk("cipher_rstn_soft", 32'(c_rstn), 0);
        rd(A_STATUS, 32'h0002_0000, "status_flushed");
        stall = 1'b0;
        wr(A_CTRL, 32'h3, "ctrl_reen");
        req_q.push_back(blk(8));
        for (int j = 0; j < 4; j++) wr(A_DIN, wv(8, j), "din_blk8");
        repeat (40) @(posedge clk);
        #1;
        rd(A_STATUS, 32'h0000_0100, "status_one_out");
        for (int j = 0; j < 4; j++) rd(A_DOUT, ~wv(8, j), "dout_blk8");

        // DONE set coinciding with a W1C clear
        wr(A_IRQ, 32'h1, "w1c_pre");
        repeat (2) @(posedge clk);
        #1;
        chk("irq_pre_clear", 32'(irq), 0);
        rd(A_IRQ, 32'h0, "irq_stat_clear");
        stall = 1'b1;
        req_q.push_back(blk(9));
        for (int j = 0; j < 4; j++) wr(A_DIN, wv(9, j), "din_blk9");
        repeat (20) @(posedge clk);
        @(negedge clk);
        force_valid = 1'b1;
        wr(A_IRQ, 32'h1, "w1c_vs_set");
        force_valid = 1'b0;
        stall = 1'b0;
        rd(A_IRQ, 32'h1, "done_set_wins");
        chk("irq_set_wins", 32'(irq), 1);
        wr(A_IRQ, 32'h1, "w1c_late");
        chk("irq_lag", 32'(irq), 1);
        @(posedge clk); #1;
        chk("irq_low_after_w1c", 32'(irq), 0);
        for (int j = 0; j < 4; j++) rd(A_DOUT, ~wv(9, j), "dout_blk9");

        // illegal accesses leave state untouched
        apb(1'b1, A_STATUS, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1, "wr_status_err");
        apb(1'b1, 12'h040, 32'h0, 32'h0, 1'b0, 1'b1, "wr_unmapped_err");
        apb(1'b0, A_DIN, 32'h0, 32'h0, 1'b1, 1'b1, "rd_din_err");
        apb(1'b1, A_WORDS, 32'h0, 32'h0, 1'b0, 1'b1, "wr_words_err");
        apb(1'b1, A_DOUT, 32'h0, 32'h0, 1'b0, 1'b1, "wr_dout_err");
        rd(A_CTRL, 32'h3, "ctrl_kept");
        rd(A_STATUS, 32'h0002_0000, "status_kept");

        repeat (5) @(posedge clk);
        #1;
        chk("pready_one_cycle_per_xfer", 32'(pready_cycles), 32'(xfers));
        chk("apb_q_drained", 32'(apb_q.size()), 0);
        chk("req_q_drained", 32'(req_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
